// File: rtl/tinyqv_mem_pkg.sv
// Shared types for the TinyQV memory scheduler: FSM state encoding and
// data transaction size codes with a helper to clamp them to the configured width.
package tinyqv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INSTR  = 2'd1,
    ST_DREAD  = 2'd2,
    ST_DWRITE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_1B = 2'd0;
  localparam logic [1:0] SZ_2B = 2'd1;
  localparam logic [1:0] SZ_4B = 2'd2;
  localparam logic [1:0] SZ_8B = 2'd3;

  function automatic logic [1:0] max_size(input int unsigned data_bytes);
    case (data_bytes)
      1:       return SZ_1B;
      2:       return SZ_2B;
      4:       return SZ_4B;
      default: return SZ_8B;
    endcase
  endfunction

  function automatic logic [1:0] size_clamp(input logic [1:0] sz, input logic [1:0] max_sz);
    return (sz > max_sz) ? max_sz : sz;
  endfunction

endpackage

// File: rtl/tinyqv_prefetch_fifo.sv
// Byte-wide prefetch FIFO for instruction bytes. A push is accepted while full
// only when a pop happens in the same cycle; flush empties it and wins over push/pop.
module tinyqv_prefetch_fifo
  import tinyqv_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [7:0]       i_wdata,
  output logic [7:0]       o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rstn && !i_flush && w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tinyqv_mem_sched.sv
// TinyQV memory scheduler: shares one QSPI controller between instruction
// prefetch and CPU data reads/writes, resuming fetch on its own after data traffic.
module tinyqv_mem_sched
  import tinyqv_mem_pkg::*;
#(
  parameter int ADDR_W     = 25,
  parameter int DATA_BYTES = 4,
  parameter int PF_DEPTH   = 4,
  parameter int SZ_W       = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ADDR_W-2:0]       i_instr_addr,
  input  logic                    i_instr_restart,
  input  logic                    i_instr_pop,
  output logic                    o_instr_valid,
  output logic [7:0]              o_instr_data,
  input  logic                    i_data_read,
  input  logic                    i_data_write,
  input  logic [SZ_W-1:0]         i_data_size,
  input  logic [ADDR_W-1:0]       i_data_addr,
  input  logic [8*DATA_BYTES-1:0] i_data_to_write,
  output logic                    o_data_done,
  output logic [8*DATA_BYTES-1:0] o_data_from_read,
  output logic [ADDR_W-1:0]       o_q_addr,
  output logic [7:0]              o_q_wdata,
  output logic                    o_q_start_read,
  output logic                    o_q_start_write,
  output logic                    o_q_stall,
  output logic                    o_q_stop,
  input  logic [7:0]              i_q_rdata,
  input  logic                    i_q_data_ready,
  input  logic                    i_q_data_req,
  input  logic                    i_q_busy
);

  localparam int         LOG_DB = $clog2(DATA_BYTES);
  localparam int         IDX_W  = (LOG_DB < 1) ? 1 : LOG_DB;
  localparam int         CNT_W  = $clog2(PF_DEPTH) + 1;
  localparam logic [1:0] MAX_SZ = max_size(DATA_BYTES);

  state_t                  r_state;
  logic [ADDR_W-1:0]       r_fetch_addr;
  logic                    r_fetch_en;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        r_last;
  logic [8*DATA_BYTES-1:0] r_rdata;
  logic                    r_done;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [7:0]       w_fifo_rdata;
  logic             w_data_pend;
  logic             w_start_read;
  logic             w_start_write;
  logic             w_start_instr;
  logic             w_stop;
  logic             w_stall;
  logic [1:0]       w_size_eff;
  logic [IDX_W-1:0] w_last_new;
  logic [IDX_W-1:0] w_wsel;

  tinyqv_prefetch_fifo #(
    .DEPTH (PF_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_instr_restart),
    .i_wdata (i_q_rdata),
    .o_rdata (w_fifo_rdata),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_size_eff = size_clamp(2'(i_data_size), MAX_SZ);
  assign w_last_new = IDX_W'((32'd1 << w_size_eff) - 32'd1);
  assign w_data_pend = i_data_read | i_data_write;

  // Bytes arriving during a restart belong to the old stream and are dropped.
  assign w_push = (r_state == ST_INSTR) && i_q_data_ready && !i_instr_restart;
  assign w_pop  = i_instr_pop && !w_empty && !i_instr_restart;

  always_comb begin
    w_start_read  = 1'b0;
    w_start_write = 1'b0;
    w_start_instr = 1'b0;
    w_stop        = 1'b0;
    w_stall       = (r_state == ST_INSTR) && (w_count == CNT_W'(PF_DEPTH)) && !i_instr_pop;
    case (r_state)
      ST_IDLE: begin
        if (!i_q_busy) begin
          if (i_data_read)
            w_start_read = 1'b1;
          else if (i_data_write)
            w_start_write = 1'b1;
          else if (r_fetch_en && !w_full && !i_instr_restart)
            w_start_instr = 1'b1;
        end
      end
      // Preempt fetch only on a halfword boundary or while stalled.
      ST_INSTR:  w_stop = i_instr_restart ||
                          (w_data_pend && ((i_q_data_ready && r_fetch_addr[0]) || w_stall));
      ST_DREAD:  w_stop = i_q_data_ready && (r_idx == r_last);
      ST_DWRITE: w_stop = i_q_data_req && (r_idx == r_last);
      default:   w_stop = 1'b0;
    endcase
    if (!rstn) begin
      w_start_read  = 1'b0;
      w_start_write = 1'b0;
      w_start_instr = 1'b0;
      w_stop        = 1'b0;
      w_stall       = 1'b0;
    end
  end

  assign w_wsel = (r_state == ST_DWRITE) ? r_idx : '0;

  assign o_q_start_read  = w_start_read | w_start_instr;
  assign o_q_start_write = w_start_write;
  assign o_q_stop        = w_stop;
  assign o_q_stall       = w_stall;
  assign o_q_addr        = (w_start_read | w_start_write) ? i_data_addr :
                           w_start_instr ? r_fetch_addr : '0;
  assign o_q_wdata       = (rstn && (r_state == ST_DWRITE || w_start_write)) ?
                           i_data_to_write[8*w_wsel +: 8] : 8'h00;
  assign o_instr_valid   = !w_empty;
  assign o_instr_data    = w_empty ? 8'h00 : w_fifo_rdata;
  assign o_data_done     = r_done;
  assign o_data_from_read = r_rdata;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_fetch_addr <= '0;
      r_fetch_en   <= 1'b0;
      r_idx        <= '0;
      r_last       <= '0;
      r_rdata      <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_instr_restart) begin
        r_fetch_en   <= 1'b1;
        r_fetch_addr <= {i_instr_addr, 1'b0};
      end else if (w_push) begin
        r_fetch_addr <= r_fetch_addr + 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start_read) begin
            r_state <= ST_DREAD;
            r_idx   <= '0;
            r_last  <= w_last_new;
            for (int i = 0; i < DATA_BYTES; i++) begin
              if (i > int'(w_last_new)) r_rdata[8*i +: 8] <= 8'h00;
            end
          end else if (w_start_write) begin
            r_state <= ST_DWRITE;
            r_idx   <= '0;
            r_last  <= w_last_new;
          end else if (w_start_instr) begin
            r_state <= ST_INSTR;
          end
        end
        ST_INSTR: begin
          if (w_stop) r_state <= ST_IDLE;
        end
        ST_DREAD: begin
          if (i_q_data_ready) begin
            r_rdata[8*r_idx +: 8] <= i_q_rdata;
            r_idx                 <= r_idx + 1'b1;
            if (r_idx == r_last) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DWRITE: begin
          if (i_q_data_req) begin
            r_idx <= r_idx + 1'b1;
            if (r_idx == r_last) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyqv_mem_sched.sv
// Directed bench for tinyqv_mem_sched: the bench plays both the CPU and the
// QSPI controller cycle by cycle and compares against hand-computed values.
module tb_tinyqv_mem_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic [23:0] instrAddr;
  logic        instrRestart;
  logic        instrPop;
  logic        instrValid;
  logic [7:0]  instrData;
  logic        dataRead;
  logic        dataWrite;
  logic [1:0]  dataSize;
  logic [24:0] dataAddr;
  logic [31:0] dataToWrite;
  logic        dataDone;
  logic [31:0] dataFromRead;
  logic [24:0] qAddr;
  logic [7:0]  qWdata;
  logic        qStartRead;
  logic        qStartWrite;
  logic        qStall;
  logic        qStop;
  logic [7:0]  qRdata;
  logic        qDataReady;
  logic        qDataReq;
  logic        qBusy;

  int checkCount = 0;
  int errorCount = 0;

  tinyqv_mem_sched dut (
    .clk              (clk),
    .rstn             (rstn),
    .i_instr_addr     (instrAddr),
    .i_instr_restart  (instrRestart),
    .i_instr_pop      (instrPop),
    .o_instr_valid    (instrValid),
    .o_instr_data     (instrData),
    .i_data_read      (dataRead),
    .i_data_write     (dataWrite),
    .i_data_size      (dataSize),
    .i_data_addr      (dataAddr),
    .i_data_to_write  (dataToWrite),
    .o_data_done      (dataDone),
    .o_data_from_read (dataFromRead),
    .o_q_addr         (qAddr),
    .o_q_wdata        (qWdata),
    .o_q_start_read   (qStartRead),
    .o_q_start_write  (qStartWrite),
    .o_q_stall        (qStall),
    .o_q_stop         (qStop),
    .i_q_rdata        (qRdata),
    .i_q_data_ready   (qDataReady),
    .i_q_data_req     (qDataReq),
    .i_q_busy         (qBusy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ready, input logic [7:0] rdata,
                               input logic req, input logic busy);
    qDataReady = ready;
    qRdata     = rdata;
    qDataReq   = req;
    qBusy      = busy;
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " done"}, dataDone, 0);
    checkOutput({tag, " fromRead"}, dataFromRead, 0);
    checkOutput({tag, " startRd"}, qStartRead, 0);
    checkOutput({tag, " startWr"}, qStartWrite, 0);
    checkOutput({tag, " stop"}, qStop, 0);
    checkOutput({tag, " stall"}, qStall, 0);
    checkOutput({tag, " valid"}, instrValid, 0);
    checkOutput({tag, " idata"}, instrData, 0);
    checkOutput({tag, " qaddr"}, qAddr, 0);
    checkOutput({tag, " wdata"}, qWdata, 0);
  endtask

  initial begin
    rstn = 1'b0; instrAddr = '0; instrRestart = 0; instrPop = 0;
    dataRead = 0; dataWrite = 0; dataSize = 0; dataAddr = '0; dataToWrite = '0;
    applyStimulus(0, 8'h00, 0, 0);
    tick(); tick();
    checkAllZero("reset");

    // Restart at 0x100 -> fetch at byte address 0x200, fill FIFO, stall.
    rstn = 1'b1; instrRestart = 1; instrAddr = 24'h000100;
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("restart cycle no start", qStartRead, 0);
    tick();
    instrRestart = 0;
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("fetch start", qStartRead, 1);
    checkOutput("fetch addr", qAddr, 25'h0000200);
    tick();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 8'hB0 + 8'(k), 0, 1);
      checkOutput("fill no stall", qStall, 0);
      tick();
    end
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("full stall", qStall, 1);
    checkOutput("full valid", instrValid, 1);
    checkOutput("full head", instrData, 8'hB0);
    checkOutput("full no stop", qStop, 0);

    // Pop two bytes, then a 4B read preempts fetch on the next odd byte.
    instrPop = 1;
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("pop clears stall", qStall, 0);
    tick();
    checkOutput("head after pop", instrData, 8'hB1);
    tick();
    instrPop = 0; dataRead = 1; dataSize = 2'd2; dataAddr = 25'h1000004;
    applyStimulus(1, 8'hC4, 0, 1);
    checkOutput("even byte no stop", qStop, 0);
    tick();
    applyStimulus(1, 8'hC5, 0, 1);
    checkOutput("odd byte stop", qStop, 1);
    checkOutput("stop excl start", qStartRead, 0);
    tick();
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("busy no start", qStartRead, 0);
    tick();
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("read start", qStartRead, 1);
    checkOutput("read start nowr", qStartWrite, 0);
    checkOutput("read addr", qAddr, 25'h1000004);
    tick();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 8'(8'h11 * (k + 1)), 0, 1);
      checkOutput("read stop timing", qStop, (k == 3) ? 1 : 0);
      checkOutput("no early done", dataDone, 0);
      tick();
    end
    dataRead = 0; instrPop = 1;
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("read done", dataDone, 1);
    checkOutput("read word", dataFromRead, 32'h44332211);
    checkOutput("full no fetch", qStartRead, 0);
    checkOutput("head B2", instrData, 8'hB2);
    tick();
    instrPop = 0;
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("done one cycle", dataDone, 0);
    checkOutput("resume start", qStartRead, 1);
    checkOutput("resume addr", qAddr, 25'h0000206);
    tick();
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("head B3", instrData, 8'hB3);

    // Fill to full, then restart while stalled.
    applyStimulus(1, 8'hD6, 0, 1);
    checkOutput("refill no stall", qStall, 0);
    tick();
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("refull stall", qStall, 1);
    instrRestart = 1; instrAddr = 24'h000800;
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("restart stop", qStop, 1);
    tick();
    instrRestart = 0;
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("flushed", instrValid, 0);
    checkOutput("restart busy wait", qStartRead, 0);
    tick();
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("restart start", qStartRead, 1);
    checkOutput("restart addr", qAddr, 25'h0001000);
    tick();

    // 1B write of 0xA5 preempts fetch after byte 0x1001.
    dataWrite = 1; dataSize = 2'd0; dataAddr = 25'h0123456; dataToWrite = 32'h123456A5;
    applyStimulus(1, 8'hE0, 0, 1);
    checkOutput("wr even no stop", qStop, 0);
    tick();
    applyStimulus(1, 8'hE1, 0, 1);
    checkOutput("wr odd stop", qStop, 1);
    tick();
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("write start", qStartWrite, 1);
    checkOutput("write not read", qStartRead, 0);
    checkOutput("write addr", qAddr, 25'h0123456);
    checkOutput("write start wdata", qWdata, 8'hA5);
    tick();
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("write wdata", qWdata, 8'hA5);
    checkOutput("write no req no stop", qStop, 0);
    tick();
    applyStimulus(0, 8'h00, 1, 1);
    checkOutput("write 1B stop", qStop, 1);
    tick();
    dataWrite = 0;
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("write done", dataDone, 1);
    checkOutput("post write fetch", qStartRead, 1);
    checkOutput("post write addr", qAddr, 25'h0001002);
    checkOutput("post write nowr", qStartWrite, 0);
    tick();

    // Read and write together: read first, write after done and idle controller.
    dataRead = 1; dataWrite = 1; dataSize = 2'd0; dataAddr = 25'h0000040; dataToWrite = 32'h0000005A;
    applyStimulus(1, 8'hF2, 0, 1);
    checkOutput("rw even no stop", qStop, 0);
    tick();
    applyStimulus(1, 8'hF3, 0, 1);
    checkOutput("rw odd stop", qStop, 1);
    tick();
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("rw read first", qStartRead, 1);
    checkOutput("rw write held", qStartWrite, 0);
    checkOutput("rw addr", qAddr, 25'h0000040);
    tick();
    applyStimulus(1, 8'h77, 0, 1);
    checkOutput("1B read stop", qStop, 1);
    tick();
    dataRead = 0;
    applyStimulus(0, 8'h00, 0, 1);
    checkOutput("1B read done", dataDone, 1);
    checkOutput("1B upper cleared", dataFromRead, 32'h00000077);
    checkOutput("rw busy no write", qStartWrite, 0);
    tick();
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("rw write start", qStartWrite, 1);
    checkOutput("rw write wdata", qWdata, 8'h5A);
    tick();
    applyStimulus(0, 8'h00, 1, 1);
    checkOutput("rw write stop", qStop, 1);
    tick();
    dataWrite = 0;
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("rw write done", dataDone, 1);
    checkOutput("rw full no fetch", qStartRead, 0);

    // Fetch address wrap at the top of the address space.
    instrRestart = 1; instrAddr = 24'hFFFFFF;
    applyStimulus(0, 8'h00, 0, 0);
    tick();
    instrRestart = 0;
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("top start", qStartRead, 1);
    checkOutput("top addr", qAddr, 25'h1FFFFFE);
    tick();
    dataRead = 1; dataSize = 2'd1; dataAddr = 25'h0000010;
    applyStimulus(1, 8'h90, 0, 1);
    checkOutput("top even no stop", qStop, 0);
    tick();
    applyStimulus(1, 8'h91, 0, 1);
    checkOutput("top odd stop", qStop, 1);
    tick();
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("2B read start", qStartRead, 1);
    checkOutput("2B read addr", qAddr, 25'h0000010);
    tick();
    applyStimulus(1, 8'hAA, 0, 1);
    checkOutput("2B first no stop", qStop, 0);
    tick();
    applyStimulus(1, 8'hBB, 0, 1);
    checkOutput("2B last stop", qStop, 1);
    tick();
    dataRead = 0;
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("2B done", dataDone, 1);
    checkOutput("2B word", dataFromRead, 32'h0000BBAA);
    checkOutput("wrap start", qStartRead, 1);
    checkOutput("wrap addr", qAddr, 25'h0000000);
    tick();

    // Reset in the middle of a 4B read.
    dataRead = 1; dataSize = 2'd2; dataAddr = 25'h0000200;
    applyStimulus(1, 8'h00, 0, 1);
    tick();
    applyStimulus(1, 8'h01, 0, 1);
    checkOutput("pre-reset stop", qStop, 1);
    tick();
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("pre-reset read start", qStartRead, 1);
    tick();
    applyStimulus(1, 8'h5C, 0, 1);
    tick();
    applyStimulus(1, 8'h5D, 0, 1);
    tick();
    rstn = 1'b0; dataRead = 0;
    applyStimulus(0, 8'h00, 0, 1);
    tick();
    checkAllZero("midreset");
    tick();
    rstn = 1'b1;
    applyStimulus(0, 8'h00, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("no done after reset", dataDone, 0);
      checkOutput("no fetch after reset", qStartRead, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
